lfsr_rand: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator with a built-in bounded-draw engine for the game engine. The shift register runs continuously on the game tick enable and supports seed loading. A request/acknowledge port returns uniformly distributed values in `[0, limit)` by rejection sampling, used for spawn positions, enemy choices and similar draws. It supersedes the fixed 3-bit generator.

---
 rtl/lfsr_rand.sv | 122 ++++++++++++
 tb/tb_lfsr_rand.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand.sv
// Fibonacci LFSR pseudo-random generator with a req/ack bounded-draw engine (rejection sampling).
// Optional macro LFSR_ZERO_GUARD_EN: a zero seed loads DEFAULT_SEED instead, so the register never locks at 0.
module lfsr_rand #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(8'h01)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] out,
  output logic             lockup
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit_m1;
  logic [WIDTH-1:0] cand;

  // Smallest 2^k-1 covering x: OR of every right shift of x.
  function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      r = r | (x >> i);
    end
    return r;
  endfunction

`ifdef LFSR_ZERO_GUARD_EN
  assign load_val = (seed == '0) ? DEFAULT_SEED : seed;
  assign lockup   = 1'b0;
`else
  assign load_val = seed;
  assign lockup   = (state_q == '0);
`endif

  assign out   = state_q;
  assign ready = ready_q;
  assign valid = valid_q;
  assign value = value_q;

  // Next-state for shift register and draw FSM.
  always_comb begin
    state_d  = load ? load_val : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    limit_m1 = limit - WIDTH'(1);
    cand     = state_q & mask_q;
    fsm_d    = fsm_q;
    limit_d  = limit_q;
    mask_d   = mask_q;
    value_d  = value_q;
    valid_d  = valid_q;

    case (fsm_q)
      IDLE: begin
        if (req) begin
          limit_d = limit;
          mask_d  = (limit <= WIDTH'(1)) ? '1 : smear(limit_m1);
          fsm_d   = DRAW;
        end
      end
      DRAW: begin
        // limit 1 has only one legal outcome, so it is forced rather than sampled.
        if (limit_q == WIDTH'(1)) begin
          value_d = '0;
          valid_d = 1'b1;
          fsm_d   = DONE;
        end else if ((limit_q == '0) || (cand < limit_q)) begin
          value_d = cand;
          valid_d = 1'b1;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          valid_d = 1'b0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    ready_d = (fsm_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= DEFAULT_SEED;
      limit_q <= '0;
      mask_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (clk_en) begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      limit_q <= limit_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rand.sv
// Directed self-checking bench for lfsr_rand (WIDTH=8, TAPS=B8, DEFAULT_SEED=01).
module tb_lfsr_rand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       load;
  logic [7:0] seed;
  logic       req;
  logic [7:0] limit;
  logic       ack;
  logic       ready;
  logic       valid;
  logic [7:0] value;
  logic [7:0] out;
  logic       lockup;

  int checks = 0;
  int errors = 0;

  lfsr_rand #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load(load), .seed(seed),
    .req(req), .limit(limit), .ack(ack), .ready(ready), .valid(valid),
    .value(value), .out(out), .lockup(lockup)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled edge followed by one disabled edge.
  task automatic etick();
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    tick();
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; load = 1'b0; seed = 8'h00;
    req = 1'b0; limit = 8'h00; ack = 1'b0;
    #23;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || value !== 8'h00 || out !== 8'h01 || lockup !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b value=%h out=%h lockup=%b, required 1 0 00 01 0",
               ready, valid, value, out, lockup);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_free_run();
    logic [7:0] exp_seq [7];
    bit early;
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (out !== exp_seq[k]) begin
        errors++;
        $display("FAIL free_run[%0d]: out=%h required %h", k + 1, out, exp_seq[k]);
      end
    end
    early = 1'b0;
    for (int k = 8; k < 255; k++) begin
      tick();
      if (out === 8'h01) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL free_run_repeat: early=%b required 0", early);
    end
    tick();
    checks++;
    if (out !== 8'h01) begin
      errors++;
      $display("FAIL free_run_period: out=%h required 01", out);
    end
  endtask

  task automatic test_single_draw();
    load = 1'b1; seed = 8'h01;
    tick();
    load = 1'b0; req = 1'b1; limit = 8'd5;
    tick();
    req = 1'b0;
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL draw_accept: ready=%b valid=%b required 0 0", ready, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || value !== 8'd2) begin
      errors++;
      $display("FAIL draw_result: valid=%b value=%h required 1 02", valid, value);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || value !== 8'd2 || ready !== 1'b0) begin
        errors++;
        $display("FAIL draw_hold[%0d]: valid=%b value=%h ready=%b required 1 02 0", k, valid, value, ready);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || value !== 8'd2) begin
      errors++;
      $display("FAIL draw_ack: ready=%b valid=%b value=%h required 1 0 02", ready, valid, value);
    end
  endtask

  task automatic test_rejection();
    load = 1'b1; seed = 8'h11;
    tick();
    load = 1'b0; req = 1'b1; limit = 8'd3;
    tick();
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL reject[%0d]: valid=%b required 0", k, valid);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b1 || value !== 8'd2 || out !== 8'h1C) begin
      errors++;
      $display("FAIL reject_accept: valid=%b value=%h out=%h required 1 02 1C", valid, value, out);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_clk_en();
    load = 1'b1; seed = 8'h11;
    etick();
    load = 1'b0; req = 1'b1; limit = 8'd3;
    etick();
    req = 1'b0;
    etick();
    etick();
    checks++;
    if (valid !== 1'b0 || out !== 8'h8E) begin
      errors++;
      $display("FAIL clk_en_reject: valid=%b out=%h required 0 8E", valid, out);
    end
    clk_en = 1'b0;
    tick();
    tick();
    checks++;
    if (valid !== 1'b0 || out !== 8'h8E || ready !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_hold: valid=%b out=%h ready=%b required 0 8E 0", valid, out, ready);
    end
    etick();
    checks++;
    if (valid !== 1'b1 || value !== 8'd2) begin
      errors++;
      $display("FAIL clk_en_result: valid=%b value=%h required 1 02", valid, value);
    end
    ack = 1'b1;
    etick();
    ack = 1'b0;
    // Asynchronous reset in the middle of a draw.
    load = 1'b1; seed = 8'h11;
    tick();
    load = 1'b0; req = 1'b1; limit = 8'd3;
    tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1 || out !== 8'h01) begin
      errors++;
      $display("FAIL reset_mid_draw: valid=%b ready=%b out=%h required 0 1 01", valid, ready, out);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1 || out !== 8'h02) begin
      errors++;
      $display("FAIL after_reset: valid=%b ready=%b out=%h required 0 1 02", valid, ready, out);
    end
  endtask

  task automatic test_limit_edges();
    load = 1'b1; seed = 8'h23;
    tick();
    load = 1'b0; req = 1'b1; limit = 8'd0;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || value !== 8'h47) begin
      errors++;
      $display("FAIL limit0: valid=%b value=%h required 1 47", valid, value);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 1'b1; limit = 8'd1;
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || value !== 8'h00) begin
      errors++;
      $display("FAIL limit1: valid=%b value=%h required 1 00", valid, value);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || ready !== 1'b0 || value !== 8'h00) begin
        errors++;
        $display("FAIL req_in_done[%0d]: valid=%b ready=%b value=%h required 1 0 00", k, valid, ready, value);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; req = 1'b0;
    checks++;
    if (valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL limit1_ack: valid=%b ready=%b required 0 1", valid, ready);
    end
  endtask

  task automatic test_zero_seed();
    logic [7:0] exp_out;
    logic       exp_lock;
    logic [7:0] exp_val;
`ifdef LFSR_ZERO_GUARD_EN
    exp_out = 8'h01; exp_lock = 1'b0; exp_val = 8'h02;
`else
    exp_out = 8'h00; exp_lock = 1'b1; exp_val = 8'h00;
`endif
    load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    checks++;
    if (out !== exp_out || lockup !== exp_lock) begin
      errors++;
      $display("FAIL zero_load: out=%h lockup=%b required %h %b", out, lockup, exp_out, exp_lock);
    end
    req = 1'b1; limit = 8'd7;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || value !== exp_val) begin
      errors++;
      $display("FAIL zero_draw: valid=%b value=%h required 1 %h", valid, value, exp_val);
    end
`ifndef LFSR_ZERO_GUARD_EN
    checks++;
    if (out !== 8'h00 || lockup !== 1'b1) begin
      errors++;
      $display("FAIL zero_stuck: out=%h lockup=%b required 00 1", out, lockup);
    end
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_draw();
    test_rejection();
    test_clk_en();
    test_limit_edges();
    test_zero_seed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
